// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Rotate right so that bit 'sh' of the input lands at bit 0 of the result.
    function automatic logic [N_REQ-1:0] rotate_right(
        input logic [N_REQ-1:0] v,
        input logic [IDX_W-1:0] sh
    );
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/prio_encoder83.sv
// Combinational 8:3 priority encoder; the lowest set bit wins.
module prio_encoder83
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_vec,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_any
);

    always_comb begin
        out_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                out_idx = IDX_W'(i);
            end
        end
    end

    assign out_any = |in_vec;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with one-cycle grant latency and no preemption.
// Optional grant-length limit is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] iReq,
    input  logic             iRelease,
    output logic [N_REQ-1:0] oGnt,
    output logic [IDX_W-1:0] oGntIdx,
    output logic             oValid,
    output logic             oTimeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT_CYCLES must be within 2..255");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] rel_idx;
    logic             req_any;
    logic [IDX_W-1:0] sel_idx;
    logic             normal_end;
    logic             limit_hit;

    // Rotating by ptr makes the requester at ptr the highest priority.
    assign req_rot = rotate_right(iReq, ptr_q);

    prio_encoder83 u_prio (
        .in_vec  (req_rot),
        .out_idx (rel_idx),
        .out_any (req_any)
    );

    assign sel_idx    = rel_idx + ptr_q;
    assign normal_end = iRelease || !iReq[idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign limit_hit = (cnt_q == 8'(TIMEOUT_CYCLES));
    assign oTimeout  = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                if (req_any) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (normal_end || limit_hit) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
                    timeout_d = limit_hit && !normal_end;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign oGnt    = gnt_q;
    assign oGntIdx = idx_q;
    assign oValid  = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected grants, a monitor checks them.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] iReq;
    logic       iRelease;
    logic [7:0] oGnt;
    logic [2:0] oGntIdx;
    logic       oValid;
    logic       oTimeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int idx;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    int   low_cnt    = 0;

    rr_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iRelease (iRelease),
        .oGnt     (oGnt),
        .oGntIdx  (oGntIdx),
        .oValid   (oValid),
        .oTimeout (oTimeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: checks grant encoding every cycle and pops one expectation per new grant.
    always @(negedge clk) begin
        checks++;
        if (oValid ? (oGnt !== (8'h01 << oGntIdx)) : (oGnt !== 8'h00 || oGntIdx !== 3'd0)) begin
            failures++;
            $display("FAIL encoding: got gnt=%h idx=%0d valid=%b", oGnt, oGntIdx, oValid);
        end
        if (oValid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got idx=%0d expected none", oGntIdx);
            end else begin
                mon_e = exp_q.pop_front();
                $display("grant idx=%0d gnt=%h idle_before=%0d (expected idx=%0d)",
                         oGntIdx, oGnt, low_cnt, mon_e.idx);
                check("grant_idx", 32'(oGntIdx), 32'(mon_e.idx));
                if (mon_e.gap >= 0) begin
                    check("idle_gap", 32'(low_cnt), 32'(mon_e.gap));
                end
            end
        end
        if (oValid) low_cnt = 0;
        else        low_cnt = low_cnt + 1;
        prev_valid = oValid;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!oValid && n < 40) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(oValid), 32'd1);
    endtask

    task automatic release_after(input int hold);
        wait_valid();
        tick(hold);
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        iReq     = 8'h00;
        iRelease = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        rst      = 1'b1;
        iReq     = 8'h00;
        iRelease = 1'b0;
        tick(2);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_gnt", 32'(oGnt), 32'd0);
        check("rst_idx", 32'(oGntIdx), 32'd0);
        check("rst_timeout", 32'(oTimeout), 32'd0);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", 32'(oValid), 32'd0);
            check("idle_gnt", 32'(oGnt), 32'd0);
            check("idle_idx", 32'(oGntIdx), 32'd0);
        end

        // Two requesters, rotation and wrap
        push(0, -1); push(7, 1); push(0, 1);
        iReq = 8'h81;
        release_after(3);
        release_after(3);
        release_after(3);
        iReq = 8'h00;
        tick(2);

        // All requesting: full rotation
        do_reset();
        push(0, -1);
        for (int i = 1; i < 8; i++) push(i, 1);
        push(0, 1);
        iReq = 8'hFF;
        for (int i = 0; i < 9; i++) release_after(0);
        iReq = 8'h00;
        tick(2);

        // Release coinciding with new requests
        do_reset();
        push(3, -1); push(4, 1);
        iReq = 8'h08;
        wait_valid();
        tick(1);
        iReq     = 8'h30;
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        check("coincide_end_valid", 32'(oValid), 32'd0);
        release_after(0);
        iReq = 8'h00;
        tick(2);

        // Reset mid-grant
        do_reset();
        push(5, -1); push(0, -1);
        iReq = 8'h20;
        wait_valid();
        tick(2);
        rst  = 1'b1;
        iReq = 8'h21;
        tick();
        check("midrst_valid", 32'(oValid), 32'd0);
        check("midrst_gnt", 32'(oGnt), 32'd0);
        check("midrst_idx", 32'(oGntIdx), 32'd0);
        check("midrst_timeout", 32'(oTimeout), 32'd0);
        rst = 1'b0;
        release_after(0);
        iReq = 8'h00;
        tick(2);

        // Other requests during a grant do not preempt
        do_reset();
        push(2, -1); push(3, 1);
        iReq = 8'h04;
        wait_valid();
        iReq = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nopreempt_idx", 32'(oGntIdx), 32'd2);
            check("nopreempt_valid", 32'(oValid), 32'd1);
        end
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        release_after(0);
        iReq = 8'h00;
        tick(2);

`ifdef ARB_TIMEOUT_EN
        // Grant force-ended after 4 cycles, then release exactly at the limit
        do_reset();
        push(2, -1); push(2, 1);
        iReq = 8'h04;
        wait_valid();
        hi = 0;
        while (oValid && hi < 20) begin
            hi++;
            tick();
        end
        check("timeout_len", 32'(hi), 32'd4);
        check("timeout_pulse", 32'(oTimeout), 32'd1);
        tick();
        check("timeout_pulse_end", 32'(oTimeout), 32'd0);
        check("regrant_valid", 32'(oValid), 32'd1);
        tick(3);
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        iReq     = 8'h00;
        check("limit_release_timeout", 32'(oTimeout), 32'd0);
        check("limit_release_valid", 32'(oValid), 32'd0);
        tick(2);
`else
        // Grants are unbounded without the limit
        do_reset();
        push(2, -1);
        iReq = 8'h04;
        wait_valid();
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (oValid) hi++;
            check("unbounded_timeout", 32'(oTimeout), 32'd0);
        end
        check("unbounded_len", 32'(hi), 32'd30);
        iRelease = 1'b1;
        tick();
        iRelease = 1'b0;
        iReq     = 8'h00;
        check("unbounded_end_valid", 32'(oValid), 32'd0);
        tick(2);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
